// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the pipelined RV32I core.
//   XLEN             : datapath / address width (only 32 supported)
//   NOP_INSTR        : canonical bubble (addi x0,x0,0), also used by the ID/EX flush
//   DEFAULT_RESET_PC : default fetch address after reset
//   PERF_*           : slot indices of the front-end performance counters
package riscv_pipe_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int PERF_NUM   = 3;
    localparam int PERF_INSTR = 0;
    localparam int PERF_STALL = 1;
    localparam int PERF_FLUSH = 2;

endpackage

// File: rtl/pipe_perf_counters.sv
// Bank of N free-running W-bit event counters.
// Each counter wraps at 2^W, clears synchronously and counts by one on any
// clock edge where its enable is high (clear has priority).
// Ports:
//   clk      : rising-edge clock
//   i_clr    : synchronous clear of every counter
//   i_en     : per-counter increment enable, bit gi drives counter gi
//   o_counts : counter values, counter gi at bits [gi*W +: W]
module pipe_perf_counters #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           i_clr,
    input  logic [N-1:0]   i_en,
    output logic [N*W-1:0] o_counts
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cnt
            logic [W-1:0] r_count;

            always_ff @(posedge clk) begin
                if (i_clr) begin
                    r_count <= '0;
                end else if (i_en[gi]) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_counts[gi*W +: W] = r_count;
        end
    endgenerate

endmodule

// File: rtl/fetch_decode_front.sv
// Pipeline front end: fetch PC, synchronous-read instruction memory address,
// and the IF/ID pipeline register, steered by the hazard unit's
// StallF / StallD / FlushD / PcSrcE commands. Also keeps front-end counters.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   StallF, StallD      : hold fetch PC / hold IF/ID register
//   FlushD              : replace IF/ID contents with a NOP bubble
//   PcSrcE, PCTargetE   : redirect fetch to PCTargetE (taken branch/jump)
//   ImemAddr            : next-PC, presented to the 1-cycle-latency imem
//   ImemRdata           : imem data for the address presented last cycle (= PCF)
//   InstrD, PCD,
//   PCPlus4D, ValidD    : IF/ID register contents seen by Decode
//   InstrCount          : valid instructions accepted into Decode
//   StallCount          : cycles IF/ID was held
//   FlushCount          : cycles IF/ID was flushed
module fetch_decode_front #(
    parameter logic [31:0] RESET_PC = riscv_pipe_pkg::DEFAULT_RESET_PC,
    parameter int          XLEN     = riscv_pipe_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PcSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ImemAddr,
    input  logic [XLEN-1:0] ImemRdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [31:0]     InstrCount,
    output logic [31:0]     StallCount,
    output logic [31:0]     FlushCount
);

    import riscv_pipe_pkg::*;

    logic [XLEN-1:0] r_pcf;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pcplus4f;
    logic            r_fetch_primed;
    logic            w_fetch_valid;
    logic            w_load;
    logic            w_load_valid;
    logic [PERF_NUM-1:0]    w_perf_en;
    logic [PERF_NUM*32-1:0] w_perf_counts;

    // Next-PC mux: redirect beats a fetch stall.
    always_comb begin
        w_pc_next = w_pcplus4f;
        if (reset) begin
            w_pc_next = RESET_PC[XLEN-1:0];
        end else if (PcSrcE) begin
            w_pc_next = PCTargetE;
        end else if (StallF) begin
            w_pc_next = r_pcf;
        end
    end

    assign w_pcplus4f = r_pcf + XLEN'(4);

    // The memory is addressed with next-PC, so its registered output always
    // belongs to PCF; a stalled PC simply re-reads the same word.
    assign ImemAddr = w_pc_next;

    always_ff @(posedge clk) begin
        r_pcf <= w_pc_next;
    end

    // While reset is high the memory is being handed RESET_PC, so the word on
    // ImemRdata is trustworthy from the first cycle after reset onwards.
    // FetchValid is therefore low during reset and high on the next cycle.
    always_ff @(posedge clk) begin
        r_fetch_primed <= 1'b1;
    end

    assign w_fetch_valid = r_fetch_primed & ~reset;

    assign w_load       = ~reset & ~FlushD & ~StallD;
    assign w_load_valid = w_load & w_fetch_valid;

    // IF/ID register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD   <= NOP_INSTR[XLEN-1:0];
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (w_fetch_valid) begin
                InstrD   <= ImemRdata;
                PCD      <= r_pcf;
                PCPlus4D <= w_pcplus4f;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR[XLEN-1:0];
                PCD      <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_perf_en             = '0;
        w_perf_en[PERF_INSTR] = w_load_valid;
        w_perf_en[PERF_STALL] = StallD & ~FlushD;
        w_perf_en[PERF_FLUSH] = FlushD;
    end

    pipe_perf_counters #(
        .N (PERF_NUM),
        .W (32)
    ) u_perf (
        .clk      (clk),
        .i_clr    (reset),
        .i_en     (w_perf_en),
        .o_counts (w_perf_counts)
    );

    assign InstrCount = w_perf_counts[PERF_INSTR*32 +: 32];
    assign StallCount = w_perf_counts[PERF_STALL*32 +: 32];
    assign FlushCount = w_perf_counts[PERF_FLUSH*32 +: 32];

endmodule

// File: tb/tb_fetch_decode_front.sv
// Self-checking bench for fetch_decode_front: a directed table of hand-derived
// vectors followed by random stimulus, both scored against a cycle-level
// behavioural model of the front end.
module tb_fetch_decode_front;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PcSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ImemAddr, ImemRdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [31:0] InstrCount, StallCount, FlushCount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_decode_front #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PcSrcE     (PcSrcE),
        .PCTargetE  (PCTargetE),
        .ImemAddr   (ImemAddr),
        .ImemRdata  (ImemRdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .InstrCount (InstrCount),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    // Instruction memory contents are a hash of the address, so every address
    // (including 0xFFFF_FFFC) holds a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Synchronous-read instruction memory with one cycle of latency.
    always @(posedge clk) ImemRdata <= mem_word(ImemAddr);

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pcf = '0, m_instr = NOP, m_pcd = '0, m_pcp4 = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_ic = '0, m_sc = '0, m_fc = '0;

    function automatic logic [31:0] mdl_next_pc();
        if (reset)       return RST_PC;
        else if (PcSrcE) return PCTargetE;
        else if (StallF) return m_pcf;
        else             return m_pcf + 32'd4;
    endfunction

    // One clock edge of the front end, from the rules: the word in Fetch is
    // whatever memory holds at PCF.
    task automatic mdl_edge();
        logic [31:0] npc;
        npc = mdl_next_pc();
        if (reset) begin
            m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
            m_ic = 0; m_sc = 0; m_fc = 0;
        end else if (FlushD) begin
            m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
            m_fc++;
        end else if (StallD) begin
            m_sc++;
        end else begin
            m_instr = mem_word(m_pcf); m_pcd = m_pcf; m_pcp4 = m_pcf + 32'd4;
            m_valid = 1; m_ic++;
        end
        m_pcf = npc;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model_outputs();
        chk("InstrD",     InstrD,           m_instr);
        chk("PCD",        PCD,              m_pcd);
        chk("PCPlus4D",   PCPlus4D,         m_pcp4);
        chk("ValidD",     {31'd0, ValidD},  {31'd0, m_valid});
        chk("InstrCount", InstrCount,       m_ic);
        chk("StallCount", StallCount,       m_sc);
        chk("FlushCount", FlushCount,       m_fc);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, sf, sd, fd, ps;
        logic [31:0] tgt;
        logic [31:0] exp_addr;   // ImemAddr with these inputs applied
        logic [31:0] exp_pcd;    // PCD after the edge
        logic        exp_v;      // ValidD after the edge
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    initial begin
        logic [31:0] exp_instr, exp_p4;

        //          rst sf sd fd ps tgt            addr           pcd           v
        vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0,         32'h0,         1'b0}; // reset
        vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h4,         32'h0,         1'b1}; // cycle 0
        vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h8,         32'h4,         1'b1};
        vt[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,         32'h8,         32'h4,         1'b1}; // stall 1
        vt[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,         32'h8,         32'h4,         1'b1}; // stall 2
        vt[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'hC,         32'h8,         1'b1};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h10,        32'hC,         1'b1};
        vt[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 32'h100,       32'h100,       32'h0,         1'b0}; // redirect
        vt[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h104,       32'h100,       1'b1};
        vt[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b1, 32'h200,       32'h200,       32'h0,         1'b0}; // all at once
        vt[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h204,       32'h200,       1'b1};
        vt[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         1'b0};
        vt[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1'b1}; // wrap
        vt[13] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1'b1};
        vt[14] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1'b1};
        vt[15] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 32'h0,         32'h0,         32'h0,         1'b0}; // reset mid-stall
        vt[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h4,         32'h0,         1'b1};

        reset = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PcSrcE = 0; PCTargetE = 0;

        for (int i = 0; i < NV; i++) begin
            reset = vt[i].rst; StallF = vt[i].sf; StallD = vt[i].sd;
            FlushD = vt[i].fd; PcSrcE = vt[i].ps; PCTargetE = vt[i].tgt;
            #1;
            chk($sformatf("vec%0d ImemAddr", i), ImemAddr, vt[i].exp_addr);
            chk($sformatf("vec%0d model ImemAddr", i), ImemAddr, mdl_next_pc());
            @(posedge clk);
            mdl_edge();
            #1;
            exp_instr = vt[i].exp_v ? mem_word(vt[i].exp_pcd) : NOP;
            exp_p4    = vt[i].exp_v ? vt[i].exp_pcd + 32'd4 : 32'h0;
            chk($sformatf("vec%0d PCD", i),      PCD,              vt[i].exp_pcd);
            chk($sformatf("vec%0d ValidD", i),   {31'd0, ValidD},  {31'd0, vt[i].exp_v});
            chk($sformatf("vec%0d InstrD", i),   InstrD,           exp_instr);
            chk($sformatf("vec%0d PCPlus4D", i), PCPlus4D,         exp_p4);
            chk_model_outputs();
            $display("vec %0d: addr=%h PCD=%h V=%0d instr=%h ic=%0d sc=%0d fc=%0d",
                     i, vt[i].exp_addr, PCD, ValidD, InstrD, InstrCount, StallCount, FlushCount);
            // Directed counter milestones.
            if (i == 3)  chk("InstrCount after 3 loads", InstrCount, 32'd2 + 32'd0 + (vt[i].sd ? 32'd0 : 32'd1));
            if (i == 4)  chk("StallCount after 2-cycle stall", StallCount, 32'd2);
            if (i == 7)  chk("FlushCount after redirect", FlushCount, 32'd1);
            if (i == 15) chk("counters cleared", InstrCount | StallCount | FlushCount, 32'd0);
        end

        // ---------------- random phase ----------------
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(63) == 0);
            StallF    = ($urandom_range(3) == 0);
            StallD    = StallF ? ($urandom_range(7) != 0) : ($urandom_range(9) == 0);
            FlushD    = ($urandom_range(5) == 0);
            PcSrcE    = ($urandom_range(7) == 0);
            PCTargetE = $urandom() & 32'hFFFF_FFFC;
            if (PcSrcE && ($urandom_range(3) != 0)) FlushD = 1'b1;
            #1;
            chk("rand ImemAddr", ImemAddr, mdl_next_pc());
            @(posedge clk);
            mdl_edge();
            #1;
            chk_model_outputs();
            $display("rand %0d: r=%0d sf=%0d sd=%0d fd=%0d ps=%0d PCD=%h V=%0d ic=%0d sc=%0d fc=%0d",
                     n, reset, StallF, StallD, FlushD, PcSrcE, PCD, ValidD,
                     InstrCount, StallCount, FlushCount);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_decode_front.md
# fetch_decode_front

Pipeline front end that executes the stall/flush/redirect commands issued by the hazard unit: holds the fetch PC, drives a synchronous-read instruction memory, and owns the IF/ID pipeline register. It obeys `StallF`, `StallD`, `FlushD` and `PcSrcE`/`PCTargetE`, inserting NOP bubbles on flush. It also keeps front-end performance counters. It sits between instruction memory and the decode stage of the pipelined RV32I core.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `XLEN`, 32, data/address width (only 32 supported)
- `clk` in 1 — rising-edge clock
- `reset` in 1 — synchronous, active-high
- `StallF` in 1 — hold PCF
- `StallD` in 1 — hold IF/ID register
- `FlushD` in 1 — squash IF/ID (bubble)
- `PcSrcE` in 1 — taken branch/jump in Execute
- `PCTargetE` in 32 — redirect target
- `ImemAddr` out 32 — instruction memory read address (sync read, 1-cycle latency)
- `ImemRdata` in 32 — data for address presented previous cycle
- `InstrD` out 32 — instruction in Decode
- `PCD` out 32 — PC of `InstrD`
- `PCPlus4D` out 32 — `PCD`+4
- `ValidD` out 1 — `InstrD` is a real instruction
- `InstrCount` out 32 — valid instructions accepted into Decode
- `StallCount` out 32 — cycles IF/ID held
- `FlushCount` out 32 — cycles IF/ID flushed

## Operation
- Next-PC: `reset` → `RESET_PC`; else `PcSrcE` → `PCTargetE`; else `StallF` → PCF; else PCF+4. Redirect wins over `StallF`.
- `ImemAddr` = next-PC (combinational). `ImemRdata` therefore always corresponds to PCF. No refetch logic is needed on stall, because the held address is re-read.
- `InstrF` = `ImemRdata`; `PCPlus4F` = PCF+4, mod 2^32 (0xFFFF_FFFC+4 → 0).
- IF/ID update priority: `reset` > `FlushD` > `StallD` > load.
  - Flush: `InstrD`=NOP (32'h0000_0013), `ValidD`=0, `PCD`/`PCPlus4D`=0.
  - Stall: hold all fields.
  - Load: capture PCF, PCF+4, `InstrF`; `ValidD`=1.
- Counters are 32-bit, wrap at 2^32, cleared by `reset`, and increment on the clock edge:
  - `InstrCount`: on a load edge.
  - `StallCount`: when `StallD`&!`FlushD`.
  - `FlushCount`: when `FlushD`.
- No FSM beyond the first-fetch valid flag `FetchValid`:
  - `reset` → 0; next cycle → 1.
  - While `FetchValid`=0, a load edge captures a bubble (NOP, `ValidD`=0) and `InstrCount` does not increment.

## Timing
- Reset values:
  - PCF=`RESET_PC`
  - `ImemAddr`=`RESET_PC` during reset
  - `InstrD`=NOP, `ValidD`=0, `PCD`=0, `PCPlus4D`=0
  - all counters 0
- Cycle 0 after reset deassertion: PCF=`RESET_PC`, `ImemRdata`=mem[`RESET_PC`], `FetchValid`=1.
- Cycle 1: `InstrD`=mem[`RESET_PC`], `ValidD`=1.
- Fetch-to-Decode latency is 1 cycle.
- Redirect: `PcSrcE` at cycle n → PCF=`PCTargetE` at n+1 and `InstrD`=mem[target] at n+2. `FlushD` at n kills the wrong-path instruction.
- Multi-cycle stall (`StallF`=`StallD`=1 for k cycles): PCF and IF/ID held exactly k cycles; no instruction lost or duplicated.
- `FlushD`&`StallD` together: flush wins.
- `PcSrcE`&`StallF` together: redirect wins.
- `reset` mid-stall or mid-redirect: all state returns to reset values on that edge.

## Structure
- Shared package `riscv_pipe_pkg`: `NOP_INSTR`=32'h0000_0013, `XLEN`, default `RESET_PC`. The same NOP constant is used by the ID/EX flush.
- One sub-module, `pipe_perf_counters`: three 32-bit wrap counters with synchronous clear and per-counter enables. The PC mux and IF/ID register stay in the top module.

## Test plan
- Reset release, memory holds sequential words at 0x0,0x4,0x8 → `ImemAddr` 0x0,0x4,0x8,0xC…; `InstrD`=mem[0] at cycle 1 with `PCD`=0, `PCPlus4D`=4; `InstrCount`=3 after cycle 3.
- `StallF`=`StallD`=1 for 2 cycles while PCF=0x8 → `ImemAddr` stays 0x8, `InstrD` holds mem[0x4], `StallCount`=2; after release, mem[0x8] then mem[0xC] with no gap or duplicate.
- `PcSrcE`=1, `PCTargetE`=0x100, `FlushD`=1 for one cycle → next `InstrD`=NOP with `ValidD`=0, following `InstrD`=mem[0x100] with `PCD`=0x100; `FlushCount`=1.
- `FlushD`=1 and `StallD`=1 together, plus `PcSrcE`=1 with `StallF`=1 → IF/ID bubbled and PCF=`PCTargetE` next cycle.
- PCF=0xFFFF_FFFC, no stall → `PCPlus4D`=0 and next PCF=0x0.
- Assert `reset` during a 3-cycle stall → next cycle PCF=`RESET_PC`, `ValidD`=0, all counters 0.
